// File: rtl/jk_bank_sequencer.sv
// Command-driven sequencer for a bank of WIDTH JK flip-flops (hold/clear/set/toggle, count runs).
// Optional down-counting is built only when JK_SEQ_COUNT_DOWN_EN is defined.
module jk_bank_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_len,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StExec, StCount} state_e;

  localparam logic [2:0] OpClear     = 3'b001;
  localparam logic [2:0] OpSet       = 3'b010;
  localparam logic [2:0] OpToggle    = 3'b011;
  localparam logic [2:0] OpCountUp   = 3'b100;
  localparam logic [2:0] OpCountDown = 3'b101;

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] mask_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] j, k, t_up, q_next;
  logic             accept, is_count;

  always_comb begin
    accept   = cmd_valid && cmd_ready;
    is_count = (cmd_op == OpCountUp);
`ifdef JK_SEQ_COUNT_DOWN_EN
    is_count = is_count || (cmd_op == OpCountDown);
`endif
  end

  // Ripple T enables: bit i toggles when all lower bits are 1 (up)
  always_comb begin
    t_up[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) t_up[i] = t_up[i-1] & q[i-1];
  end

`ifdef JK_SEQ_COUNT_DOWN_EN
  logic [WIDTH-1:0] t_dn;
  always_comb begin
    t_dn[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) t_dn[i] = t_dn[i-1] & ~q[i-1];
  end
`endif

  // Count ops reaching StExec (zero length) and reserved opcodes fall through as HOLD.
  always_comb begin
    j = '0;
    k = '0;
    unique case (state_q)
      StExec: begin
        case (op_q)
          OpClear:  k = mask_q;
          OpSet:    j = mask_q;
          OpToggle: begin
            j = mask_q;
            k = mask_q;
          end
          default: ;
        endcase
      end
      StCount: begin
        j = t_up;
        k = t_up;
`ifdef JK_SEQ_COUNT_DOWN_EN
        if (op_q == OpCountDown) begin
          j = t_dn;
          k = t_dn;
        end
`endif
      end
      default: ;
    endcase
    q_next = (j & ~q) | (~k & q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
      q         <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      q    <= q_next;
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            op_q      <= cmd_op;
            mask_q    <= cmd_mask;
            cnt_q     <= cmd_len;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state_q   <= (is_count && (cmd_len != '0)) ? StCount : StExec;
          end
        end
        StExec: begin
          state_q   <= StIdle;
          busy      <= 1'b0;
          done      <= 1'b1;
          cmd_ready <= 1'b1;
        end
        StCount: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Directed bench for jk_bank_sequencer; down-count expectations follow JK_SEQ_COUNT_DOWN_EN.
module tb_jk_bank_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [7:0] cmd_len;
  logic [3:0] q;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  jk_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_mask  (cmd_mask),
    .cmd_len   (cmd_len),
    .q         (q),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called at posedge+1 with cmd_ready high; returns at E0+1.
  task automatic issue(input logic [2:0] op, input logic [3:0] mask, input logic [7:0] len);
    cmd_op    = op;
    cmd_mask  = mask;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic single_op(input string tag, input logic [2:0] op, input logic [3:0] mask,
                           input logic [7:0] len, input logic [3:0] exp_q);
    issue(op, mask, len);
    check({tag, "_busy0"},  32'(busy), 32'd1);
    check({tag, "_ready0"}, 32'(cmd_ready), 32'd0);
    check({tag, "_done0"},  32'(done), 32'd0);
    @(posedge clk); #1;
    check({tag, "_q"},      32'(q), 32'(exp_q));
    check({tag, "_done1"},  32'(done), 32'd1);
    check({tag, "_busy1"},  32'(busy), 32'd0);
    check({tag, "_ready1"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] up_seq [5];
    logic [3:0] dn_seq [3];
    up_seq = '{4'hF, 4'h0, 4'h1, 4'h2, 4'h3};
    dn_seq = '{4'h0, 4'hF, 4'hE};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0; cmd_len = '0;
    #2;
    check("rst_q", 32'(q), 32'h0);
    check("rst_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Command presented across the first edge after release must not be taken
    cmd_valid = 1'b1; cmd_op = 3'b010; cmd_mask = 4'hF;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_edge_busy", 32'(busy), 32'd0);
    check("first_edge_q", 32'(q), 32'h0);
    check("first_edge_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b0;

    single_op("set_a", 3'b010, 4'hA, 8'd0, 4'hA);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", 32'(q), 32'h0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_ready", 32'(cmd_ready), 32'd0);
    #3 rst_n = 1'b1;
    #1 check("rel_ready_pre", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    check("rel_ready_post", 32'(cmd_ready), 32'd1);

    single_op("set5", 3'b010, 4'h5, 8'd0, 4'h5);
    single_op("tog3", 3'b011, 4'h3, 8'd0, 4'h6);

    single_op("clr_up", 3'b001, 4'hF, 8'd0, 4'h0);
    single_op("set_up", 3'b010, 4'hE, 8'd0, 4'hE);
    issue(3'b100, 4'h0, 8'd5);
    // Hold a different, valid command during the run: it must be ignored
    cmd_valid = 1'b1; cmd_op = 3'b011; cmd_mask = 4'hF; cmd_len = 8'd1;
    check("up_busy0", 32'(busy), 32'd1);
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      check($sformatf("up_q%0d", s + 1), 32'(q), 32'(up_seq[s]));
      check($sformatf("up_done%0d", s + 1), 32'(done), 32'(s == 4));
      check($sformatf("up_busy%0d", s + 1), 32'(busy), 32'(s != 4));
    end
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("up_done_after", 32'(done), 32'd0);
    check("up_q_after", 32'(q), 32'h3);

    single_op("len0", 3'b100, 4'hF, 8'd0, 4'h3);
    @(posedge clk); #1;
    check("len0_done_once", 32'(done), 32'd0);
    single_op("op111", 3'b111, 4'hF, 8'd4, 4'h3);
    @(posedge clk); #1;
    check("op111_done_once", 32'(done), 32'd0);

    single_op("clr_dn", 3'b001, 4'hF, 8'd0, 4'h0);
    single_op("set_dn", 3'b010, 4'h1, 8'd0, 4'h1);
`ifdef JK_SEQ_COUNT_DOWN_EN
    issue(3'b101, 4'h0, 8'd3);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      check($sformatf("dn_q%0d", s + 1), 32'(q), 32'(dn_seq[s]));
      check($sformatf("dn_done%0d", s + 1), 32'(done), 32'(s == 2));
    end
`else
    single_op("dn_off", 3'b101, 4'h0, 8'd3, 4'h1);
    @(posedge clk); #1;
    check("dn_off_hold", 32'(q), 32'(dn_seq[0] | 4'h1));
`endif

    single_op("clr_ab", 3'b001, 4'hF, 8'd0, 4'h0);
    issue(3'b100, 4'h0, 8'd10);
    @(posedge clk); #1;
    check("ab_q1", 32'(q), 32'h1);
    @(posedge clk); #1;
    check("ab_q2", 32'(q), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("ab_rst_q", 32'(q), 32'h0);
    check("ab_rst_busy", 32'(busy), 32'd0);
    #3 rst_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      check($sformatf("ab_no_done%0d", s), 32'(done), 32'd0);
      check($sformatf("ab_idle_q%0d", s), 32'(q), 32'h0);
    end
    single_op("post_set", 3'b010, 4'h9, 8'd0, 4'h9);
    single_op("post_clr", 3'b001, 4'hF, 8'd0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
